// File: rtl/half_subtractor_pkg.sv
// Shared constants for the half subtractor: per-lane truth table and reset value.
// The tables are indexed by {a, b} and double as a reference model.
package half_subtractor_pkg;

  localparam logic       RST_VAL = 1'b0;
  localparam int         MAX_W   = 32;

  // Bit {a,b} of each table gives the lane output for that input pair.
  localparam logic [3:0] LANE_S  = 4'b0110;
  localparam logic [3:0] LANE_C  = 4'b0010;

  typedef struct packed {
    logic c;
    logic s;
  } lane_res_t;

  function automatic lane_res_t lane_ref(input logic a, input logic b);
    lane_res_t r;
    r.c = LANE_C[{a, b}];
    r.s = LANE_S[{a, b}];
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] vec_ref_s(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) r[i] = lane_ref(a[i], b[i]).s;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] vec_ref_c(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) r[i] = lane_ref(a[i], b[i]).c;
    return r;
  endfunction

endpackage

// File: rtl/half_subtractor_core.sv
// One half-subtractor lane built from CMOS switch networks.
// s comes from a transmission-gate XOR, c from NAND(~a, b) plus an inverter.
module half_subtractor_core (
  input  wire logic a,
  input  wire logic b,
  output wire logic c,
  output wire logic s
);

  supply1 vdd;
  supply0 gnd;

  wire a_n;
  wire b_n;
  wire nand_o;
  wire nand_mid;

  pmos p_inv_a (a_n, vdd, a);
  nmos n_inv_a (a_n, gnd, a);

  pmos p_inv_b (b_n, vdd, b);
  nmos n_inv_b (b_n, gnd, b);

  // a=0 passes b, a=1 passes ~b; both gates in a pair conduct together, so s is always driven.
  nmos n_tg_b  (s, b,   a_n);
  pmos p_tg_b  (s, b,   a);
  nmos n_tg_bn (s, b_n, a);
  pmos p_tg_bn (s, b_n, a_n);

  pmos p_nand_a (nand_o,   vdd,      a_n);
  pmos p_nand_b (nand_o,   vdd,      b);
  nmos n_nand_a (nand_o,   nand_mid, a_n);
  nmos n_nand_b (nand_mid, gnd,      b);

  pmos p_inv_c (c, vdd, nand_o);
  nmos n_inv_c (c, gnd, nand_o);

endmodule

// File: rtl/half_subtractor.sv
// WIDTH independent half-subtractor lanes with an optional output register
// (async active-low clear) selected by REG_OUT.
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s
);

  wire [WIDTH-1:0] c_core;
  wire [WIDTH-1:0] s_core;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_subtractor_core u_core (
      .a (a[i]),
      .b (b[i]),
      .c (c_core[i]),
      .s (s_core[i])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] s_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_q <= {WIDTH{RST_VAL}};
        s_q <= {WIDTH{RST_VAL}};
      end else begin
        c_q <= c_core;
        s_q <= s_core;
      end
    end

    assign c = c_q;
    assign s = s_q;
  end else begin : g_comb
    // Clock and reset have no function in the unregistered build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign c = c_core;
    assign s = s_core;
  end

endmodule

// File: tb/tb_half_subtractor.sv
// Directed and random checks of half_subtractor in registered and
// combinational builds, against the package truth tables.
module tb_half_subtractor;
  import half_subtractor_pkg::*;

  logic clk;
  logic clk_off;
  logic rst_n;

  logic [0:0] a1, b1, c1, s1;
  logic [3:0] a4, b4, c4, s4;
  logic [7:0] a8, b8, c8, s8;

  int total;
  int bad;
  int z_seen;

  half_subtractor #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk (clk), .rst_n (rst_n), .a (a1), .b (b1), .c (c1), .s (s1)
  );

  half_subtractor #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
    .clk (clk_off), .rst_n (rst_n), .a (a4), .b (b4), .c (c4), .s (s4)
  );

  half_subtractor #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk (clk), .rst_n (rst_n), .a (a8), .b (b8), .c (c8), .s (s8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] vec_ab [4];
  logic [1:0] vec_cs [4];

  initial begin
    logic [7:0] pa, pb;
    total   = 0;
    bad     = 0;
    z_seen  = 0;
    clk_off = 1'b0;
    rst_n   = 1'b1;
    a1 = 1'b0; b1 = 1'b1;
    a4 = '0;   b4 = '0;
    a8 = '0;   b8 = '0;

    vec_ab[0] = 2'b00; vec_cs[0] = 2'b00;
    vec_ab[1] = 2'b01; vec_cs[1] = 2'b11;
    vec_ab[2] = 2'b10; vec_cs[2] = 2'b01;
    vec_ab[3] = 2'b11; vec_cs[3] = 2'b00;

    // t=5 edge loads c=1 s=1 from a=0 b=1; reset at t=7 must clear with no edge.
    edge_sample();
    chk("preload_cs", {c1, s1}, 2'b11);
    #1;
    a1 = 1'b1; b1 = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_a1b1_cs", {c1, s1}, 2'b00);
    a1 = 1'b0; b1 = 1'b1;
    #1;
    chk("rst_a0b1_cs", {c1, s1}, 2'b00);
    edge_sample();
    chk("rst_hold_cs", {c1, s1}, 2'b00);
    chk("rst_w8_cs", {c8, s8}, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {a1, b1} = vec_ab[i];
      edge_sample();
      chk($sformatf("exh_ab%b", vec_ab[i]), {c1, s1}, vec_cs[i]);
    end

    // Mid-cycle input change must not reach s before the next edge.
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0;
    edge_sample();
    chk("lat_pre_s", s1, 1'b0);
    #2;
    a1 = 1'b1;
    #1;
    chk("lat_hold_s", s1, 1'b0);
    edge_sample();
    chk("lat_edge_s", s1, 1'b1);

    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1;
    edge_sample();
    chk("mid_pre_cs", {c1, s1}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", {c1, s1}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_cs", {c1, s1}, 2'b00);
    edge_sample();
    chk("mid_post_cs", {c1, s1}, 2'b11);

    a4 = 4'b1100; b4 = 4'b1010;
    #1;
    chk("comb_s_1100_1010", s4, 4'b0110);
    chk("comb_c_1100_1010", c4, 4'b0010);
    a4 = 4'b0000; b4 = 4'b1111;
    #1;
    chk("comb_s_0000_1111", s4, 4'b1111);
    chk("comb_c_0000_1111", c4, 4'b1111);
    a4 = 4'b1111; b4 = 4'b0000;
    #1;
    chk("comb_s_1111_0000", s4, 4'b1111);
    chk("comb_c_1111_0000", c4, 4'b0000);
    a4 = 4'b0101; b4 = 4'b0101;
    #1;
    chk("comb_s_0101_0101", s4, 4'b0000);
    chk("comb_c_0101_0101", c4, 4'b0000);

    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      pa = a8;
      pb = b8;
      edge_sample();
      // Change inputs right after the edge so a missing register stage is exposed.
      a8 = ~pa;
      if ($isunknown(s8) || $isunknown(c8)) z_seen++;
      chk($sformatf("rnd%0d_s", n), s8, vec_ref_s(32'(pa), 32'(pb)));
      chk($sformatf("rnd%0d_c", n), c8, vec_ref_c(32'(pa), 32'(pb)));
    end
    chk("rnd_no_z", z_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
